uart_tx_framer: RTL and testbench

Parametrised UART transmit framer: accepts a data word over a valid/ready handshake and serialises it as start bit, 5–8 data bits LSB first, an optional parity bit and 1 or 2 stop bits. It is the sequential successor to the combinational UART parity generator. It adds selectable data width, five parity modes, stop-bit count and an internal bit-period counter. It sits between the UART register/FIFO front end and the `tx` pad.

---
 rtl/uart_tx_framer_if.sv | 20 ++
 rtl/uart_tx_framer.sv | 149 ++++++++++++++
 tb/tb_uart_tx_framer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_framer_if.sv
// Word handshake between the UART front end and the transmit framer.
// The frame configuration travels with the word so it can be latched on accept.
interface uart_tx_framer_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic [1:0] data_length;
    logic [2:0] parity_type;
    logic       stop_bits;

    modport master (
        output tx_valid, tx_data, data_length, parity_type, stop_bits,
        input  tx_ready
    );

    modport slave (
        input  tx_valid, tx_data, data_length, parity_type, stop_bits,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx_framer.sv
// UART transmit framer: start bit, 5-8 data bits LSB first, optional parity,
// 1 or 2 stop bits, each CLKS_PER_BIT cycles wide; tx is a registered output.
module uart_tx_framer #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_framer_if.slave tx_if,
    output logic            tx,
    output logic            busy,
    output logic            parity_out
);

    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [2:0]    last_bit_q, last_bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_en_q, par_en_d;
    logic          par_q, par_d;
    logic          stop2_q, stop2_d;
    logic          stop_idx_q, stop_idx_d;
    logic          tx_q, tx_d;

    logic [7:0]    mask;
    logic [7:0]    data_m;
    logic          par_calc;
    logic          par_en_calc;
    logic          bit_end;

    // Width mask and parity are evaluated on the live inputs; they only matter on accept.
    always_comb begin
        mask        = 8'hFF;
        par_calc    = 1'b0;
        par_en_calc = 1'b0;
        case (tx_if.data_length)
            2'b00:   mask = 8'h1F;
            2'b01:   mask = 8'h3F;
            2'b10:   mask = 8'h7F;
            default: mask = 8'hFF;
        endcase
        data_m = tx_if.tx_data & mask;
        case (tx_if.parity_type)
            3'b001:  begin par_calc = ~^data_m; par_en_calc = 1'b1; end
            3'b010:  begin par_calc = ^data_m;  par_en_calc = 1'b1; end
            3'b011:  begin par_calc = 1'b1;     par_en_calc = 1'b1; end
            3'b100:  begin par_calc = 1'b0;     par_en_calc = 1'b1; end
            default: begin par_calc = 1'b0;     par_en_calc = 1'b0; end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        last_bit_d = last_bit_q;
        shift_d    = shift_q;
        par_en_d   = par_en_q;
        par_d      = par_q;
        stop2_d    = stop2_q;
        stop_idx_d = stop_idx_q;
        bit_end    = (cnt_q == CNT_LAST);
        cnt_d      = bit_end ? '0 : cnt_q + 1'b1;
        tx_d       = 1'b1;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (tx_if.tx_valid) begin
                    state_d    = START;
                    shift_d    = data_m;
                    last_bit_d = {1'b1, tx_if.data_length};  // N-1 = 4 + data_length
                    par_d      = par_calc;
                    par_en_d   = par_en_calc;
                    stop2_d    = tx_if.stop_bits;
                    bit_d      = '0;
                    stop_idx_d = 1'b0;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == last_bit_q) begin
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_d = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2_q && !stop_idx_q) stop_idx_d = 1'b1;
                    else                        state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level is derived from the next state so tx lines up with state_q.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            PARITY:  tx_d = par_d;
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            last_bit_q <= '0;
            shift_q    <= '0;
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
            stop2_q    <= 1'b0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            last_bit_q <= last_bit_d;
            shift_q    <= shift_d;
            par_en_q   <= par_en_d;
            par_q      <= par_d;
            stop2_q    <= stop2_d;
            stop_idx_q <= stop_idx_d;
            tx_q       <= tx_d;
        end
    end

    assign tx_if.tx_ready = (state_q == IDLE);
    assign busy           = (state_q != IDLE);
    assign tx             = tx_q;
    assign parity_out     = par_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: stimulus pushes hand-written frames,
// a monitor captures each busy window off the tx line and compares.
module tb_uart_tx_framer;
    localparam int CPB = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic tx, busy, parity_out;

    uart_tx_framer_if bus ();

    uart_tx_framer #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_if      (bus),
        .tx         (tx),
        .busy       (busy),
        .parity_out (parity_out)
    );

    always #5 clk = ~clk;

    // frame: transmitted bit levels in line order, one character per bit period
    typedef struct {
        string name;
        string frame;
        logic  par;
        int    gap;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic check_frame(input logic [63:0] seen, input int cyc, input int gap);
        exp_t       e;
        logic [63:0] ev;
        int         n;
        if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_frame: got a %0d-cycle frame, required none", cyc);
            return;
        end
        e  = sb.pop_front();
        n  = e.frame.len();
        ev = '0;
        for (int c = 0; c < n * CPB; c++) ev[c] = (e.frame[c / CPB] == 8'h31);
        cmp({e.name, "_len"},    64'(cyc), 64'(n * CPB));
        cmp({e.name, "_tx"},     seen, ev);
        cmp({e.name, "_idle"},   64'(tx), 64'(1));
        cmp({e.name, "_parity"}, 64'(parity_out), 64'(e.par));
        if (e.gap >= 0) cmp({e.name, "_gap"}, 64'(gap), 64'(e.gap));
    endtask

    // Monitor: one capture per busy window; idle counts cycles since the last frame.
    initial begin : monitor
        bit          cap;
        int          cyc;
        int          idle;
        int          gap_seen;
        logic [63:0] seen;
        cap = 0; cyc = 0; idle = 0; gap_seen = 0; seen = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                cap  = 0;
                cyc  = 0;
                idle = 0;
            end else if (busy) begin
                if (!cap) begin
                    cap      = 1;
                    cyc      = 0;
                    seen     = '0;
                    gap_seen = idle;
                    idle     = 0;
                end
                if (cyc < 64) seen[cyc] = tx;
                cyc++;
            end else begin
                if (cap) begin
                    cap = 0;
                    check_frame(seen, cyc, gap_seen);
                end
                idle++;
            end
        end
    end

    task automatic send(input string name, input logic [7:0] d, input logic [1:0] dl,
                        input logic [2:0] pt, input logic s2, input string frame,
                        input logic par, input int gap, input bit hold, input bit expect_frame);
        exp_t e;
        int   n;
        if (expect_frame) begin
            e.name = name; e.frame = frame; e.par = par; e.gap = gap;
            sb.push_back(e);
        end
        bus.tx_data     = d;
        bus.data_length = dl;
        bus.parity_type = pt;
        bus.stop_bits   = s2;
        bus.tx_valid    = 1'b1;
        n = 0;
        while (!bus.tx_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (!bus.tx_ready) begin
            compared++;
            mismatched++;
            $display("FAIL %s_accept: tx_ready stayed 0 for %0d cycles, required 1", name, n);
        end
        @(posedge clk);
        #1;
        if (!hold) bus.tx_valid = 1'b0;
    endtask

    initial begin
        int n;
        bus.tx_valid    = 1'b0;
        bus.tx_data     = 8'h00;
        bus.data_length = 2'b11;
        bus.parity_type = 3'b000;
        bus.stop_bits   = 1'b0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        cmp("reset_tx",     64'(tx),           64'(1));
        cmp("reset_ready",  64'(bus.tx_ready), 64'(1));
        cmp("reset_busy",   64'(busy),         64'(0));
        cmp("reset_parity", 64'(parity_out),   64'(0));
        rst = 1'b1;
        @(negedge clk);

        send("s1_55_8n1",   8'h55, 2'b11, 3'b000, 1'b0, "0101010101",  1'b0, -1, 0, 1);
        send("s2_c3_7e1",   8'hC3, 2'b10, 3'b010, 1'b0, "0110000111",  1'b1, -1, 0, 1);
        send("s3_1f_5o2",   8'h1F, 2'b00, 3'b001, 1'b1, "011111011",   1'b0, -1, 0, 1);
        send("s4_mark",     8'h00, 2'b01, 3'b011, 1'b0, "000000011",   1'b1, -1, 0, 1);
        send("s4_space",    8'h00, 2'b01, 3'b100, 1'b0, "000000001",   1'b0, -1, 0, 1);
        send("s4_code5",    8'h00, 2'b01, 3'b101, 1'b0, "00000001",    1'b0, -1, 0, 1);
        send("s4_code6",    8'h00, 2'b01, 3'b110, 1'b0, "00000001",    1'b0, -1, 0, 1);
        send("s4_mark2",    8'h00, 2'b01, 3'b011, 1'b0, "000000011",   1'b1, -1, 0, 1);
        send("s4_code7",    8'h00, 2'b01, 3'b111, 1'b0, "00000001",    1'b0, -1, 0, 1);

        // Abort 0xA5 (8-bit odd) in the middle of data bit 3 (cycles 17-20 of the frame).
        send("s5_a5", 8'hA5, 2'b11, 3'b001, 1'b0, "", 1'b1, -1, 0, 0);
        repeat (18) @(negedge clk);
        cmp("s5_bit3_level",  64'(tx),         64'(0));
        cmp("s5_parity_pre",  64'(parity_out), 64'(1));
        rst = 1'b0;
        #1;
        cmp("s5_abort_tx",     64'(tx),           64'(1));
        cmp("s5_abort_ready",  64'(bus.tx_ready), 64'(1));
        cmp("s5_abort_busy",   64'(busy),         64'(0));
        cmp("s5_abort_parity", 64'(parity_out),   64'(0));
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        cmp("s5_no_resume", 64'(busy), 64'(0));
        send("s5_3c_8n1", 8'h3C, 2'b11, 3'b000, 1'b0, "0001111001", 1'b0, -1, 0, 1);

        // Back-to-back with tx_valid held; inputs churn while frame 1 is in flight.
        send("s6_81_8o1", 8'h81, 2'b11, 3'b001, 1'b0, "01000000111", 1'b1, -1, 1, 1);
        bus.tx_data     = 8'hFF;
        bus.data_length = 2'b00;
        bus.parity_type = 3'b011;
        bus.stop_bits   = 1'b1;
        repeat (12) @(negedge clk);
        send("s6_7e_6s1", 8'h7E, 2'b01, 3'b100, 1'b0, "001111101", 1'b0, 1, 0, 1);

        n = 0;
        while ((sb.size() != 0 || busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        cmp("scoreboard_drained", 64'(sb.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
